uart_rx_param: RTL and testbench

Parametrised UART receiver for the icebreaker top level. It replaces the fixed 8N1 byte receive path with a block configurable in bit period, data width, parity and stop bits. It synchronises `rx_i`, detects and qualifies start bits, and samples each bit at mid-period. Each frame is presented on a ready/valid output with parity, framing and overrun status, ready for the ALU command decoder.

---
 rtl/uart_rx_param.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised start qualification, mid-bit sampling,
// optional parity, 1-2 stop bits, and a ready/valid output register with error/overrun status.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 280,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_chk_cpb
        $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e               state_q, state_d;
    logic                 sync_q, rx_s_q, rx_prev_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_out_q, ferr_out_q, ovr_q;
    logic                 par_exp;

    // Even parity expects the XOR of the data bits; odd expects its inverse.
    assign par_exp = (^shreg_q) ^ (PARITY == 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sync_q     <= rx_i;
            rx_s_q     <= sync_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                    if (rx_s_q != par_exp) perr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (!rx_s_q) ferr_d = 1'b1;
                    // Leave half a bit early so a back-to-back start edge is not missed.
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_q) begin
                if (!valid_q || ready_i) begin
                    data_q     <= shreg_q;
                    perr_out_q <= perr_q;
                    ferr_out_q <= ferr_q;
                    valid_q    <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_out_q;
    assign frame_err_o  = ferr_out_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: default 8N1 instance plus a 7E2 instance, randomised frames
// checked against a frame-level reference model.
module tb_uart_rx_param;
    localparam int C0 = 280;
    localparam int C1 = 16;
    localparam int D1 = 7;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx0 = 1'b1, rdy0 = 1'b1, rx1 = 1'b1, rdy1 = 1'b1;
    logic [7:0]    data0;
    logic [D1-1:0] data1;
    logic          v0, pe0, fe0, ov0, busy0;
    logic          v1, pe1, fe1, ov1, busy1;

    uart_rx_param dut0 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx0), .data_o(data0), .valid_o(v0),
        .ready_i(rdy0), .parity_err_o(pe0), .frame_err_o(fe0), .overrun_o(ov0), .busy_o(busy0)
    );

    uart_rx_param #(.CLKS_PER_BIT(C1), .DATA_BITS(D1), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx1), .data_o(data1), .valid_o(v1),
        .ready_i(rdy1), .parity_err_o(pe1), .frame_err_o(fe1), .overrun_o(ov1), .busy_o(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } frm_t;

    frm_t        exp0[$], got0[$], exp1[$], got1[$];
    int unsigned cyc = 0, rise0 = 0, hi0 = 0, ovr0 = 0, ovr1 = 0;
    logic        v0_prev = 1'b0;
    int unsigned n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted word and pulse counts, sampled mid-cycle.
    always @(negedge clk) begin
        v0_prev <= v0;
        if (v0 && !v0_prev) rise0 <= cyc;
        hi0  <= hi0 + 32'(v0);
        ovr0 <= ovr0 + 32'(ov0);
        ovr1 <= ovr1 + 32'(ov1);
        if (v0 && rdy0) got0.push_back('{9'(data0), pe0, fe0});
        if (v1 && rdy1) got1.push_back('{9'(data1), pe1, fe1});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; each bit held for cpb cycles, LSB of bits first.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int nb, input int cpb);
        for (int i = 0; i < nb; i++) begin
            if (sel == 0) rx0 = bits[i];
            else          rx1 = bits[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int sel);
        frm_t e, g;
        int   n_e, n_g, n;
        n_e = (sel == 0) ? exp0.size() : exp1.size();
        n_g = (sel == 0) ? got0.size() : got1.size();
        check($sformatf("nframes%0d", sel), 32'(n_g), 32'(n_e));
        n = (n_e < n_g) ? n_e : n_g;
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin e = exp0.pop_front(); g = got0.pop_front(); end
            else          begin e = exp1.pop_front(); g = got1.pop_front(); end
            check($sformatf("data%0d_%0d", sel, i), 32'(g.data), 32'(e.data));
            check($sformatf("perr%0d_%0d", sel, i), 32'(g.pe), 32'(e.pe));
            check($sformatf("ferr%0d_%0d", sel, i), 32'(g.fe), 32'(e.fe));
        end
        exp0.delete(); got0.delete(); exp1.delete(); got1.delete();
    endtask

    task automatic frame0(input logic [7:0] d, input logic stop);
        exp0.push_back('{9'(d), 1'b0, !stop});
        send_bits(0, 16'({stop, d, 1'b0}), 10, C0);
    endtask

    // Even parity model: the expected parity bit equals the XOR of the data bits.
    task automatic frame1(input logic [D1-1:0] d, input logic p, input logic s1, input logic s2);
        exp1.push_back('{9'(d), p != (^d), !(s1 && s2)});
        send_bits(1, 16'({s2, s1, p, d, 1'b0}), 11, C1);
        if (!rx1) begin
            rx1 = 1'b1;
            repeat (C1) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned t0, hb, ob;
        logic [7:0]  d;
        logic        s;

        repeat (5) @(posedge clk);
        #1;
        check("rst_data0",  32'(data0), 32'h0);
        check("rst_valid0", 32'(v0),    32'h0);
        check("rst_perr0",  32'(pe0),   32'h0);
        check("rst_ferr0",  32'(fe0),   32'h0);
        check("rst_ovr0",   32'(ov0),   32'h0);
        check("rst_busy0",  32'(busy0), 32'h0);
        check("rst_valid1", 32'(v1),    32'h0);
        check("rst_busy1",  32'(busy1), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Default 8N1 frame with latency and single-cycle valid.
        t0 = cyc + 1;
        hb = hi0;
        frame0(8'hA5, 1'b1);
        check("latency_a5", rise0 - t0, 32'd2663);
        check("valid_width_a5", hi0 - hb, 32'd1);
        drain(0);

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            frame0(d, s);
            if (!s) begin
                rx0 = 1'b1;
                repeat (C0) @(posedge clk);
                #1;
            end
        end
        drain(0);

        // False start: 100 low cycles.
        t0 = cyc + 1;
        rx0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("fs_busy_early", 32'(busy0), 32'h1);
        rx0 = 1'b1;
        wait_cyc(t0 + 141);
        check("fs_busy_141", 32'(busy0), 32'h1);
        wait_cyc(t0 + 142);
        check("fs_busy_142", 32'(busy0), 32'h0);
        resync();
        repeat (2 * C0) @(posedge clk);
        #1;
        drain(0);

        // Framing error followed by a break; no retrigger until a fresh falling edge.
        frame0(8'h3C, 1'b0);
        repeat (3 * C0) @(posedge clk);
        #1;
        check("break_busy", 32'(busy0), 32'h0);
        drain(0);
        rx0 = 1'b1;
        repeat (C0) @(posedge clk);
        #1;
        frame0(8'h96, 1'b1);
        drain(0);

        // Overrun: consumer stalled across two back-to-back frames.
        rdy0 = 1'b0;
        ob = ovr0;
        send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10, C0);
        send_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10, C0);
        repeat (C0) @(posedge clk);
        #1;
        check("ovr_valid", 32'(v0), 32'h1);
        check("ovr_data", 32'(data0), 32'h11);
        check("ovr_pulses", ovr0 - ob, 32'd1);
        check("ovr_none_taken", 32'(got0.size()), 32'd0);
        rdy0 = 1'b1;
        resync();
        check("ovr_valid_drop", 32'(v0), 32'h0);
        exp0.push_back('{9'h011, 1'b0, 1'b0});
        drain(0);

        // Reset during data bit 4 while a previous word is still held.
        rdy0 = 1'b0;
        send_bits(0, 16'({1'b1, 8'h77, 1'b0}), 10, C0);
        check("pre_rst_valid", 32'(v0), 32'h1);
        send_bits(0, 16'({4'hF, 1'b0}), 5, C0);
        rx0 = 1'b1;
        repeat (C0 / 2) @(posedge clk);
        check("pre_rst_busy", 32'(busy0), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(data0), 32'h0);
        check("mid_rst_valid", 32'(v0), 32'h0);
        check("mid_rst_busy", 32'(busy0), 32'h0);
        check("mid_rst_flags", 32'({pe0, fe0, ov0}), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy0 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        got0.delete();
        frame0(8'h5A, 1'b1);
        drain(0);

        // 7E2 instance: directed parity cases, then randomised frames and gaps.
        frame1(7'h55, 1'b1, 1'b1, 1'b1);
        frame1(7'h55, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) begin
            frame1(7'($urandom), 1'($urandom),
                   $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
            repeat ($urandom_range(0, 2) * C1) @(posedge clk);
            #1;
        end
        repeat (2 * C1) @(posedge clk);
        #1;
        check("ovr1_none", ovr1, 32'd0);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
